// File: rtl/snake_move_scheduler.sv
// snake_move_scheduler
//
// Turns the four level-sensitive direction keys into a short queue of
// validated turn requests. Generates the periodic game tick. On each tick,
// commits at most one queued turn to the registered `direction` output.
//
// Optional feature: define SNAKE_SPEEDUP_EN to add the `grow` input. Each
// `grow` pulse shortens the tick period by SPEED_STEP, down to
// MIN_TICK_CYCLES. With the macro undefined, the period is the constant
// TICK_CYCLES.
//
// Parameters:
//   TICK_CYCLES     clock cycles per game move (>= 2)
//   QDEPTH          pending-turn queue depth (>= 1)
//   SPEED_STEP      period reduction per grow pulse (speed-up build only)
//   MIN_TICK_CYCLES period floor (speed-up build only)
//
// Ports:
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high
//   in_right, in_down, in_left, in_up
//              key levels, already synchronized
//   pause      freezes the tick counter; keys are still queued
//   grow       one-cycle speed-up pulse (SNAKE_SPEEDUP_EN only)
//   direction  committed direction: right=00 down=01 left=10 up=11
//   step       one-cycle move pulse, aligned with the new direction
//   drop       one-cycle pulse when a valid turn is lost to overflow
//   pending    queue occupancy

module snake_move_scheduler #(
  parameter int unsigned TICK_CYCLES     = 25_000_000,
  parameter int unsigned QDEPTH          = 2,
  parameter int unsigned SPEED_STEP      = 1_000_000,
  parameter int unsigned MIN_TICK_CYCLES = 5_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_right,
  input  logic                         in_down,
  input  logic                         in_left,
  input  logic                         in_up,
  input  logic                         pause,
`ifdef SNAKE_SPEEDUP_EN
  input  logic                         grow,
`endif
  output logic [1:0]                   direction,
  output logic                         step,
  output logic                         drop,
  output logic [$clog2(QDEPTH+1)-1:0]  pending
);

  localparam int unsigned PendW = $clog2(QDEPTH + 1);
  localparam int unsigned CntW  = $clog2(TICK_CYCLES + 1);

  // Elaboration-time sanity checks on the configuration.
  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("TICK_CYCLES must be at least 2");
  end
  if (QDEPTH < 1) begin : g_bad_depth
    $error("QDEPTH must be at least 1");
  end
  if (MIN_TICK_CYCLES < 2 || SPEED_STEP < 1) begin : g_bad_speed
    $error("MIN_TICK_CYCLES must be >= 2 and SPEED_STEP >= 1");
  end

  // ---------------------------------------------------------------------------
  // Key edge detection
  // ---------------------------------------------------------------------------
  logic [3:0] keys;
  logic [3:0] prev_q;
  logic [3:0] rise;
  logic       req_vld;
  logic [1:0] req_dir;

  // Bit position equals the direction encoding.
  assign keys = {in_up, in_left, in_down, in_right};
  assign rise = keys & ~prev_q;

  // A request exists only for exactly one rising key; simultaneous rises
  // are ambiguous and are ignored.
  always_comb begin
    req_vld = 1'b1;
    req_dir = 2'b00;
    case (rise)
      4'b0001: req_dir = 2'b00;
      4'b0010: req_dir = 2'b01;
      4'b0100: req_dir = 2'b10;
      4'b1000: req_dir = 2'b11;
      default: req_vld = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tick counter and period
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] period;
  logic            tick;

`ifdef SNAKE_SPEEDUP_EN
  logic [CntW-1:0] period_q, period_d;

  always_comb begin
    period_d = period_q;
    if (grow) begin
      if (32'(period_q) >= MIN_TICK_CYCLES + SPEED_STEP) begin
        period_d = period_q - CntW'(SPEED_STEP);
      end else begin
        period_d = CntW'(MIN_TICK_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= CntW'(TICK_CYCLES);
    end else begin
      period_q <= period_d;
    end
  end

  assign period = period_q;
`else
  assign period = CntW'(TICK_CYCLES);
`endif

  // ">=" rather than "==" so a count left beyond a freshly shortened period
  // still ticks on the next cycle instead of wrapping the whole counter.
  assign tick = !pause && (count_q >= period - CntW'(1));

  always_comb begin
    if (tick) begin
      count_d = '0;
    end else if (pause) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-turn queue (shift register, entry 0 is the head)
  // ---------------------------------------------------------------------------
  logic [1:0]       queue_q [QDEPTH];
  logic [1:0]       queue_d [QDEPTH];
  logic [PendW-1:0] pending_q, pending_d;
  logic [PendW-1:0] wr_idx;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       tail_dir;
  logic [1:0]       ref_dir;
  logic             turn_ok;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop_d;
  logic             step_q;
  logic             drop_q;

  always_comb begin
    tail_dir = 2'b00;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (int'(pending_q) == i + 1) begin
        tail_dir = queue_q[i];
      end
    end
  end

  // Requests are validated against the last direction the snake will have
  // taken once everything already queued is applied.
  assign ref_dir = (pending_q != '0) ? tail_dir : dir_q;
  assign turn_ok = req_vld && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b10));
  assign full    = (pending_q == PendW'(QDEPTH));
  assign pop     = tick && (pending_q != '0);
  // A pop in the same cycle frees the slot that the push then takes.
  assign push    = turn_ok && (!full || pop);
  assign drop_d  = turn_ok && full && !pop;
  assign wr_idx  = pending_q - PendW'(pop);

  always_comb begin
    for (int i = 0; i < int'(QDEPTH); i++) begin
      queue_d[i] = queue_q[i];
    end
    if (pop) begin
      for (int i = 0; i < int'(QDEPTH) - 1; i++) begin
        queue_d[i] = queue_q[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        if (int'(wr_idx) == i) begin
          queue_d[i] = req_dir;
        end
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    case ({push, pop})
      2'b10:   pending_d = pending_q + PendW'(1);
      2'b01:   pending_d = pending_q - PendW'(1);
      default: pending_d = pending_q;
    endcase
  end

  assign dir_d = pop ? queue_q[0] : dir_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // Loading the live levels means a key held through reset is not a rise.
      prev_q    <= keys;
      pending_q <= '0;
      dir_q     <= 2'b00;
      count_q   <= '0;
      step_q    <= 1'b0;
      drop_q    <= 1'b0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        queue_q[i] <= 2'b00;
      end
    end else begin
      prev_q    <= keys;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      count_q   <= count_d;
      step_q    <= tick;
      drop_q    <= drop_d;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        queue_q[i] <= queue_d[i];
      end
    end
  end

  assign direction = dir_q;
  assign step      = step_q;
  assign drop      = drop_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler with TICK_CYCLES=4, QDEPTH=2.
// A cycle table with hand-derived expectations, a behavioural model checked
// every cycle, and a scoreboard of expected step directions.

module tb_snake_move_scheduler;

  localparam int unsigned Tick = 4;
  localparam int unsigned Qd   = 2;
  localparam int unsigned Stp  = 1;
  localparam int unsigned MinP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys;  // {up, left, down, right}
  logic       pause;
`ifdef SNAKE_SPEEDUP_EN
  logic       grow;
`endif
  logic [1:0] direction;
  logic       step;
  logic       drop;
  logic [1:0] pending;

  always #5 clk = ~clk;

  snake_move_scheduler #(
    .TICK_CYCLES    (Tick),
    .QDEPTH         (Qd),
    .SPEED_STEP     (Stp),
    .MIN_TICK_CYCLES(MinP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_right (keys[0]),
    .in_down  (keys[1]),
    .in_left  (keys[2]),
    .in_up    (keys[3]),
    .pause    (pause),
`ifdef SNAKE_SPEEDUP_EN
    .grow     (grow),
`endif
    .direction(direction),
    .step     (step),
    .drop     (drop),
    .pending  (pending)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model state
  logic [3:0]  m_prev;
  logic [1:0]  mq[$];
  logic [1:0]  m_dir;
  logic        m_step;
  logic        m_drop;
  int unsigned m_cnt;
  int unsigned m_period;
  logic [1:0]  sb[$];  // expected direction for each upcoming step pulse

  task automatic model_edge();
    logic [3:0] rise;
    logic [1:0] rq;
    logic [1:0] rf;
    bit         tk;
    bit         popping;
    bit         valid;
    int         pre_size;
    if (reset) begin
      m_prev = keys;
      mq.delete();
      sb.delete();
      m_dir    = 2'b00;
      m_step   = 1'b0;
      m_drop   = 1'b0;
      m_cnt    = 0;
      m_period = Tick;
    end else begin
      rise     = keys & ~m_prev;
      tk       = !pause && (m_cnt + 1 >= m_period);
      valid    = 1'b0;
      rq       = 2'b00;
      pre_size = mq.size();
      if ($countones(rise) == 1) begin
        for (int b = 0; b < 4; b++) if (rise[b]) rq = 2'(b);
        rf    = (pre_size > 0) ? mq[$] : m_dir;
        valid = (rq != rf) && (rq != (rf ^ 2'b10));
      end
      popping = tk && (pre_size > 0);
      m_drop  = 1'b0;
      if (popping) m_dir = mq.pop_front();
      if (valid) begin
        if (pre_size < int'(Qd) || popping) mq.push_back(rq);
        else m_drop = 1'b1;
      end
      if (tk) sb.push_back(m_dir);
      m_step = tk;
      m_cnt  = tk ? 0 : (pause ? m_cnt : m_cnt + 1);
`ifdef SNAKE_SPEEDUP_EN
      if (grow) m_period = (m_period >= MinP + Stp) ? m_period - Stp : MinP;
`endif
      m_prev = keys;
    end
  endtask

  // One clock: advance the model, then compare every output.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    chk("pending", 32'(pending), 32'(mq.size()));
    chk("direction", 32'(direction), 32'(m_dir));
    chk("drop", 32'(drop), 32'(m_drop));
    chk("step", 32'(step), 32'(m_step));
    if (step === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL step_scoreboard: got step=1 expected no step at %0t", $time);
      end else begin
        chk("step_dir", 32'(direction), 32'(sb.pop_front()));
      end
    end
  endtask

  // Cycles until the next step pulse; an expired budget counts as a failure.
  task automatic wait_step(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (step !== 1'b1 && n < limit);
    if (step !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL step_timeout: got no step expected one within %0d cycles", limit);
    end
  endtask

  typedef struct {
    logic [3:0] keys;
    logic [1:0] pend;
    logic [1:0] dir;
    logic       stp;
    logic       drp;
  } vec_t;

  vec_t tbl[40];

  function automatic void setv(int i, logic [3:0] k, logic [1:0] p, logic [1:0] d,
                               logic s, logic r);
    tbl[i].keys = k;
    tbl[i].pend = p;
    tbl[i].dir  = d;
    tbl[i].stp  = s;
    tbl[i].drp  = r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  initial begin
    int n;

    // Idle ticking, reversal/duplicate rejection, fill/overflow, tail-based
    // reversal, push into empty queue on a tick, push into full queue on a
    // tick, simultaneous rises.
    setv( 0, 4'b0000, 0, 0, 0, 0);
    setv( 1, 4'b0000, 0, 0, 0, 0);
    setv( 2, 4'b0000, 0, 0, 0, 0);
    setv( 3, 4'b0000, 0, 0, 1, 0);
    setv( 4, 4'b0100, 0, 0, 0, 0);  // left: reversal of right
    setv( 5, 4'b0000, 0, 0, 0, 0);
    setv( 6, 4'b0001, 0, 0, 0, 0);  // right: duplicate
    setv( 7, 4'b0000, 0, 0, 1, 0);
    setv( 8, 4'b0010, 1, 0, 0, 0);  // down
    setv( 9, 4'b0110, 2, 0, 0, 0);  // left rises
    setv(10, 4'b1110, 2, 0, 0, 1);  // up rises, queue full
    setv(11, 4'b0000, 1, 1, 1, 0);
    setv(12, 4'b0000, 1, 1, 0, 0);
    setv(13, 4'b0000, 1, 1, 0, 0);
    setv(14, 4'b0000, 1, 1, 0, 0);
    setv(15, 4'b0000, 0, 2, 1, 0);
    setv(16, 4'b1000, 1, 2, 0, 0);  // up
    setv(17, 4'b0000, 1, 2, 0, 0);
    setv(18, 4'b0010, 1, 2, 0, 0);  // down: reversal of tail up
    setv(19, 4'b0000, 0, 3, 1, 0);
    setv(20, 4'b0000, 0, 3, 0, 0);
    setv(21, 4'b0000, 0, 3, 0, 0);
    setv(22, 4'b0000, 0, 3, 0, 0);
    setv(23, 4'b0001, 1, 3, 1, 0);  // right on a tick with empty queue
    setv(24, 4'b0000, 1, 3, 0, 0);
    setv(25, 4'b0000, 1, 3, 0, 0);
    setv(26, 4'b0000, 1, 3, 0, 0);
    setv(27, 4'b0000, 0, 0, 1, 0);
    setv(28, 4'b0010, 1, 0, 0, 0);  // down
    setv(29, 4'b0110, 2, 0, 0, 0);  // left rises
    setv(30, 4'b0000, 2, 0, 0, 0);
    setv(31, 4'b1000, 2, 1, 1, 0);  // up on a tick with full queue
    setv(32, 4'b0000, 2, 1, 0, 0);
    setv(33, 4'b0000, 2, 1, 0, 0);
    setv(34, 4'b0000, 2, 1, 0, 0);
    setv(35, 4'b0000, 1, 2, 1, 0);
    setv(36, 4'b0101, 1, 2, 0, 0);  // right+left together: ignored
    setv(37, 4'b0000, 1, 2, 0, 0);
    setv(38, 4'b0000, 1, 2, 0, 0);
    setv(39, 4'b0000, 0, 3, 1, 0);

    reset = 1'b1;
    keys  = 4'b0000;
    pause = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
    grow  = 1'b0;
`endif
    cyc();
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      keys = tbl[i].keys;
      cyc();
      chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_direction", i), 32'(direction), 32'(tbl[i].dir));
      chk($sformatf("tbl%0d_step", i), 32'(step), 32'(tbl[i].stp));
      chk($sformatf("tbl%0d_drop", i), 32'(drop), 32'(tbl[i].drp));
    end
    keys = 4'b0000;

    // Pause at count=2 for 10 cycles, then step two cycles after release.
    cyc();
    cyc();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pause_no_step", 32'(step), 32'd0);
    end
    pause = 1'b0;
    wait_step(10, n);
    chk("pause_release_latency", 32'(n), 32'd2);

    // Up held through reset: no request; first step four edges after release.
    keys  = 4'b1000;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wait_step(10, n);
    chk("first_step_latency", 32'(n), 32'd4);
    chk("held_key_pending", 32'(pending), 32'd0);
    chk("held_key_direction", 32'(direction), 32'd0);
    keys = 4'b0000;

    // Reset on the cycle a step is due suppresses it.
    cyc();
    cyc();
    keys = 4'b0010;
    cyc();
    chk("pre_reset_pending", 32'(pending), 32'd1);
    keys  = 4'b0000;
    reset = 1'b1;
    cyc();
    chk("reset_step_suppressed", 32'(step), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    reset = 1'b0;
    wait_step(10, n);
    chk("post_reset_first_step", 32'(n), 32'd4);

`ifdef SNAKE_SPEEDUP_EN
    grow = 1'b1;
    cyc();
    grow = 1'b0;
    wait_step(10, n);
    wait_step(10, n);
    chk("speed_period3", 32'(n), 32'd3);
    grow = 1'b1;
    cyc();
    grow = 1'b0;
    cyc();
    grow = 1'b1;
    cyc();
    grow = 1'b0;
    wait_step(10, n);
    wait_step(10, n);
    chk("speed_period2", 32'(n), 32'd2);
    wait_step(10, n);
    chk("speed_period2_again", 32'(n), 32'd2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wait_step(10, n);
    wait_step(10, n);
    chk("speed_reset_period4", 32'(n), 32'd4);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
